// File: rtl/sdr_pkg.sv
// -----------------------------------------------------------------------------
// sdr_pkg
//   Shared definitions for the SDRAM controller system-bus front end:
//   command-type encodings driven on cmd_type, front-end FSM state encodings
//   and the default burst length.
// -----------------------------------------------------------------------------
package sdr_pkg;

    // Default number of data beats per access
    localparam int unsigned SDR_BURST_LEN = 8;

    // Command issued to the SDRAM command/data path
    typedef enum logic [1:0] {
        CMD_RD  = 2'd0,
        CMD_WR  = 2'd1,
        CMD_REF = 2'd2
    } sdr_cmd_e;

    // Front-end FSM states
    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_WCAP,
        ST_REQ,
        ST_WDATA,
        ST_RDATA,
        ST_REF,
        ST_DONE
    } sdr_state_e;

endpackage

// File: rtl/sdr_sys_front_ref_timer.sv
// -----------------------------------------------------------------------------
// sdr_ref_timer
//   Periodic refresh timer plus the refresh-pending flag. The timer counts
//   0..REF_PERIOD-1 while i_run is high and wraps; each terminal count sets
//   the pending flag, as does an external request pulse. A refresh command
//   acknowledge clears the flag; a set in the same cycle wins, and repeated
//   requests while pending collapse into one.
//   Only built when SDR_REF_TIMER_EN is defined.
//
// Ports:
//   sys_clk     in   clock
//   sys_rst_n   in   asynchronous active-low reset
//   i_run       in   timer enable (bus initialisation complete)
//   i_ref_req   in   external refresh request pulse
//   i_ref_clr   in   refresh command accepted
//   o_ref_pend  out  refresh pending
// -----------------------------------------------------------------------------
module sdr_ref_timer
    import sdr_pkg::*;
#(
    parameter int unsigned REF_PERIOD = 1560
)(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_run,
    input  logic i_ref_req,
    input  logic i_ref_clr,
    output logic o_ref_pend
);

    localparam int unsigned CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(REF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          w_tc;

    assign w_tc = i_run && (r_cnt == TC_VAL);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend <= 1'b0;
        end else if (i_ref_req || w_tc) begin
            r_pend <= 1'b1;
        end else if (i_ref_clr) begin
            r_pend <= 1'b0;
        end
    end

    assign o_ref_pend = r_pend;

endmodule

// File: rtl/sdr_sys_front.sv
// -----------------------------------------------------------------------------
// sdr_sys_front
//   System-bus front end of the SDRAM controller. Blocks bus accesses until
//   SDRAM initialisation completes, captures write bursts into a local
//   buffer, arbitrates accesses against refresh, issues one command at a time
//   to the command/data path, returns read data and pulses sys_CYC_END when
//   an access completes.
//
// Configuration:
//   SDR_REF_TIMER_EN  defined: internal refresh timer (sdr_ref_timer) raises a
//                     refresh every REF_PERIOD cycles once sys_INIT_DONE is
//                     high. Undefined: refresh only from sys_REF_REQ.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   sys_A[23:1]               word address, sampled with sys_ADSn
//   sys_ADSn                  active-low address strobe
//   sys_R_Wn                  1 = read, 0 = write
//   sys_D                     write data, BURST_LEN cycles after strobe
//   sys_REF_REQ               external refresh request pulse
//   sys_INIT_DONE             bus may issue accesses
//   sys_CYC_END               one-cycle access-complete pulse
//   sys_RD_D, sys_RD_VLD      read data and valid
//   sys_ERR                   sticky protocol error
//   init_done_i               init-complete level from the command block
//   cmd_req/type/addr         command request to the command path
//   cmd_ack, cmd_done         command accepted / finished
//   wr_req, wr_data           write beat to the data path
//   rd_vld_i, rd_data_i       read beat from the data path
// -----------------------------------------------------------------------------
module sdr_sys_front
    import sdr_pkg::*;
#(
    parameter int unsigned BURST_LEN  = SDR_BURST_LEN,
    parameter int unsigned REF_PERIOD = 1560
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [23:1] sys_A,
    input  logic        sys_ADSn,
    input  logic        sys_R_Wn,
    input  logic [15:0] sys_D,
    input  logic        sys_REF_REQ,
    output logic        sys_INIT_DONE,
    output logic        sys_CYC_END,
    output logic [15:0] sys_RD_D,
    output logic        sys_RD_VLD,
    output logic        sys_ERR,
    input  logic        init_done_i,
    output logic        cmd_req,
    output logic [1:0]  cmd_type,
    output logic [23:1] cmd_addr,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    output logic        wr_req,
    output logic [15:0] wr_data,
    input  logic        rd_vld_i,
    input  logic [15:0] rd_data_i
);

    localparam int unsigned IDX_W = $clog2(BURST_LEN);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);

    sdr_state_e       r_state;
    sdr_state_e       w_next;

    logic [23:1]      r_addr;
    logic             r_is_rd;
    logic [15:0]      r_buf [BURST_LEN];
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_beat;
    logic             r_done_seen;
    logic             r_ref_acked;
    logic             r_init_done;
    logic             r_err;
    logic [15:0]      r_rd_d;
    logic             r_rd_vld;

    logic             w_strobe;
    logic             w_beat_in;
    logic [CNT_W-1:0] w_beat_nxt;
    logic             w_done_any;
    logic             w_ref_pend;
    logic             w_ref_clr;
    sdr_cmd_e         w_acc_cmd;

    assign w_strobe   = !sys_ADSn;
    assign w_done_any = r_done_seen || cmd_done;
    // Beats beyond BURST_LEN are not counted (they only flag an error)
    assign w_beat_in  = rd_vld_i && (r_beat != CNT_FULL);
    assign w_beat_nxt = r_beat + CNT_W'(w_beat_in);
    assign w_acc_cmd  = r_is_rd ? CMD_RD : CMD_WR;
    // Only the first acknowledge of a refresh clears the pending flag
    assign w_ref_clr  = (r_state == ST_REF) && cmd_ack && !r_ref_acked;

    // ---------------------------------------------------------------- refresh
`ifdef SDR_REF_TIMER_EN
    sdr_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_run      (r_init_done),
        .i_ref_req  (sys_REF_REQ),
        .i_ref_clr  (w_ref_clr),
        .o_ref_pend (w_ref_pend)
    );
`else
    logic r_ref_pend;
    logic w_unused_ref_period;

    assign w_unused_ref_period = |REF_PERIOD;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ref_pend <= 1'b0;
        end else if (sys_REF_REQ) begin
            r_ref_pend <= 1'b1;
        end else if (w_ref_clr) begin
            r_ref_pend <= 1'b0;
        end
    end

    assign w_ref_pend = r_ref_pend;
`endif

    // ------------------------------------------------------- state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_WAIT_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_WAIT_INIT: if (init_done_i) w_next = ST_IDLE;
            ST_IDLE: begin
                // A bus strobe always wins over a pending refresh
                if (w_strobe) begin
                    w_next = sys_R_Wn ? ST_REQ : ST_WCAP;
                end else if (w_ref_pend) begin
                    w_next = ST_REF;
                end
            end
            ST_WCAP:  if (r_idx == CNT_LAST) w_next = ST_REQ;
            ST_REQ:   if (cmd_ack) w_next = r_is_rd ? ST_RDATA : ST_WDATA;
            ST_WDATA: if ((r_idx == CNT_FULL) && w_done_any) w_next = ST_DONE;
            ST_RDATA: if ((w_beat_nxt == CNT_FULL) && w_done_any) w_next = ST_DONE;
            ST_REF:   if ((r_ref_acked || cmd_ack) && cmd_done) w_next = ST_IDLE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_WAIT_INIT;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        cmd_req     = 1'b0;
        cmd_type    = CMD_RD;
        wr_req      = 1'b0;
        wr_data     = '0;
        sys_CYC_END = 1'b0;
        unique case (r_state)
            ST_REQ: begin
                cmd_req  = 1'b1;
                cmd_type = w_acc_cmd;
            end
            ST_WDATA: begin
                cmd_type = w_acc_cmd;
                if (r_idx != CNT_FULL) begin
                    wr_req  = 1'b1;
                    wr_data = r_buf[r_idx[IDX_W-1:0]];
                end
            end
            ST_RDATA: cmd_type = w_acc_cmd;
            ST_REF: begin
                cmd_req  = !r_ref_acked;
                cmd_type = CMD_REF;
            end
            ST_DONE:  sys_CYC_END = 1'b1;
            default: ;
        endcase
    end

    assign cmd_addr      = r_addr;
    assign sys_INIT_DONE = r_init_done;
    assign sys_ERR       = r_err;
    assign sys_RD_D      = r_rd_d;
    assign sys_RD_VLD    = r_rd_vld;

    // -------------------------------------------------------------- datapath
    // r_idx is shared: capture index in WCAP, beat index in WDATA.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr      <= '0;
            r_is_rd     <= 1'b0;
            r_buf       <= '{default: '0};
            r_idx       <= '0;
            r_beat      <= '0;
            r_done_seen <= 1'b0;
            r_ref_acked <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_idx       <= '0;
                    r_beat      <= '0;
                    r_done_seen <= 1'b0;
                    r_ref_acked <= 1'b0;
                    if (w_strobe) begin
                        r_addr  <= sys_A;
                        r_is_rd <= sys_R_Wn;
                    end
                end
                ST_WCAP: begin
                    r_buf[r_idx[IDX_W-1:0]] <= sys_D;
                    r_idx <= (r_idx == CNT_LAST) ? '0 : r_idx + CNT_W'(1);
                end
                ST_WDATA: begin
                    if (r_idx != CNT_FULL) r_idx <= r_idx + CNT_W'(1);
                    if (cmd_done) r_done_seen <= 1'b1;
                end
                ST_RDATA: begin
                    r_beat <= w_beat_nxt;
                    if (cmd_done) r_done_seen <= 1'b1;
                end
                ST_REF: if (cmd_ack) r_ref_acked <= 1'b1;
                default: ;
            endcase
        end
    end

    // Read return: one-cycle registered copy of accepted beats
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_d   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == ST_RDATA) && w_beat_in;
            if ((r_state == ST_RDATA) && w_beat_in) r_rd_d <= rd_data_i;
        end
    end

    // Init-done flag and sticky protocol error
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (init_done_i) r_init_done <= 1'b1;
            if (w_strobe && (r_state != ST_IDLE)) r_err <= 1'b1;
            if ((r_state == ST_RDATA) && rd_vld_i && !w_beat_in) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdr_sys_front.sv
module tb_sdr_sys_front;

    localparam int unsigned BL = 8;
`ifdef SDR_REF_TIMER_EN
    localparam int unsigned RP = 16;
`else
    localparam int unsigned RP = 1560;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [23:1] sys_A;
    logic        sys_ADSn;
    logic        sys_R_Wn;
    logic [15:0] sys_D;
    logic        sys_REF_REQ;
    logic        sys_INIT_DONE;
    logic        sys_CYC_END;
    logic [15:0] sys_RD_D;
    logic        sys_RD_VLD;
    logic        sys_ERR;
    logic        init_done_i;
    logic        cmd_req;
    logic [1:0]  cmd_type;
    logic [23:1] cmd_addr;
    logic        cmd_ack;
    logic        cmd_done;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        rd_vld_i;
    logic [15:0] rd_data_i;

    int n_chk = 0;
    int n_err = 0;
    bit exp_err = 0;

    sdr_sys_front #(
        .BURST_LEN  (BL),
        .REF_PERIOD (RP)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .sys_A         (sys_A),
        .sys_ADSn      (sys_ADSn),
        .sys_R_Wn      (sys_R_Wn),
        .sys_D         (sys_D),
        .sys_REF_REQ   (sys_REF_REQ),
        .sys_INIT_DONE (sys_INIT_DONE),
        .sys_CYC_END   (sys_CYC_END),
        .sys_RD_D      (sys_RD_D),
        .sys_RD_VLD    (sys_RD_VLD),
        .sys_ERR       (sys_ERR),
        .init_done_i   (init_done_i),
        .cmd_req       (cmd_req),
        .cmd_type      (cmd_type),
        .cmd_addr      (cmd_addr),
        .cmd_ack       (cmd_ack),
        .cmd_done      (cmd_done),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .rd_vld_i      (rd_vld_i),
        .rd_data_i     (rd_data_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {24'd0, sys_INIT_DONE, sys_CYC_END, sys_RD_VLD, sys_ERR,
                              cmd_req, wr_req, cmd_type}, 32'd0);
        chk({tag, "_rd_d"}, sys_RD_D, 0);
        chk({tag, "_addr"}, cmd_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    // Write access: strobe, BL capture cycles, command handshake, beats, end.
    task automatic do_write(input logic [23:1] a, input int ack_dly, input int done_at,
                            input bit const_data, input bit ref_flag);
        logic [15:0] d [BL];
        int n_beats, first, last, end_at;
        for (int i = 0; i < BL; i++) d[i] = const_data ? 16'h5678 : 16'($urandom);
        sys_A = a; sys_R_Wn = 1'b0; sys_ADSn = 1'b0; sys_REF_REQ = ref_flag;
        tick();
        sys_ADSn = 1'b1; sys_A = 23'($urandom);
        for (int k = 0; k < BL; k++) begin
            sys_D = d[k];
            sys_REF_REQ = ref_flag && (k == 0);
            if (k == 0) chk("wcap_no_req", cmd_req, 0);
            tick();
        end
        sys_REF_REQ = 1'b0; sys_D = 16'($urandom);
        chk("wr_req_up", cmd_req, 1);
        chk("wr_type", cmd_type, 1);
        chk("wr_addr", cmd_addr, a);
        repeat (ack_dly) tick();
        chk("wr_req_hold", {cmd_req, cmd_type, cmd_addr}, {1'b1, 2'd1, a});
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("wr_req_drop", cmd_req, 0);
        n_beats = 0; first = -1; last = -1; end_at = -1;
        for (int j = 0; j < 40 && end_at < 0; j++) begin
            if (wr_req) begin
                if (first < 0) first = j;
                last = j;
                if (n_beats < BL) chk($sformatf("wr_data%0d", n_beats), wr_data, d[n_beats]);
                n_beats++;
            end
            if (sys_CYC_END) end_at = j;
            cmd_done = (j == done_at);
            tick();
        end
        cmd_done = 1'b0;
        chk("wr_beats", n_beats, BL);
        chk("wr_span", {first[15:0], last[15:0]}, {16'd0, 16'(BL - 1)});
        chk("wr_end", end_at, ((done_at > BL) ? done_at : BL) + 1);
        chk("wr_single_end", sys_CYC_END, 0);
        chk("wr_err", sys_ERR, exp_err);
    endtask

    // Read access: beats arrive with random gaps; returned data must follow
    // one cycle later in order, and the access ends once both all beats and
    // cmd_done have been seen.
    task automatic do_read(input logic [23:1] a, input int ack_dly, input int gap_pct,
                           input bit seq, input int done_at, input bit ref_flag,
                           input bit bad_strobe, input bit extra);
        logic [15:0] expq [$];
        int expt [$];
        int sent, rx, last_beat, end_at;
        bit extra_sent;
        sys_A = a; sys_R_Wn = 1'b1; sys_ADSn = 1'b0; sys_REF_REQ = ref_flag;
        tick();
        sys_ADSn = 1'b1; sys_REF_REQ = 1'b0; sys_A = 23'($urandom);
        chk("rd_req_up", cmd_req, 1);
        chk("rd_type", cmd_type, 0);
        chk("rd_addr", cmd_addr, a);
        if (bad_strobe) begin
            sys_ADSn = 1'b0; sys_R_Wn = 1'b0;
            exp_err = 1'b1;
            tick();
            sys_ADSn = 1'b1; sys_R_Wn = 1'b1;
            chk("bad_strobe_err", sys_ERR, 1);
            chk("bad_strobe_ignored", {cmd_req, cmd_type, cmd_addr}, {1'b1, 2'd0, a});
        end
        repeat (ack_dly) tick();
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("rd_req_drop", cmd_req, 0);
        sent = 0; rx = 0; last_beat = -1; end_at = -1; extra_sent = 1'b0;
        for (int j = 0; j < 80 && end_at < 0; j++) begin
            if (sys_RD_VLD) begin
                if (rx < expq.size()) begin
                    chk($sformatf("rd_data%0d", rx), sys_RD_D, expq[rx]);
                    chk($sformatf("rd_lat%0d", rx), j, expt[rx]);
                end
                rx++;
            end
            if (sys_CYC_END) end_at = j;
            cmd_done = (j == done_at);
            rd_vld_i = 1'b0;
            if (sent < BL) begin
                if ($urandom_range(99) >= gap_pct) begin
                    rd_vld_i  = 1'b1;
                    rd_data_i = seq ? 16'(sent) : 16'($urandom);
                    expq.push_back(rd_data_i);
                    expt.push_back(j + 1);
                    sent++;
                    if (sent == BL) last_beat = j;
                end
            end else if (extra && !extra_sent && end_at < 0) begin
                rd_vld_i   = 1'b1;
                rd_data_i  = 16'hdead;
                extra_sent = 1'b1;
                exp_err    = 1'b1;
            end
            tick();
        end
        rd_vld_i = 1'b0; cmd_done = 1'b0;
        chk("rd_beats", rx, BL);
        chk("rd_end", end_at, ((done_at > last_beat) ? done_at : last_beat) + 1);
        chk("rd_single_end", {sys_CYC_END, sys_RD_VLD}, 0);
        chk("rd_err", sys_ERR, exp_err);
    endtask

    // Serve a refresh that should be requested within wait_max cycles.
    task automatic do_refresh(input int wait_max);
        bit got = 1'b0;
        int ends = 0;
        int reqs = 0;
        for (int j = 0; j < wait_max && !got; j++) begin
            if (cmd_req) got = 1'b1;
            else tick();
        end
        chk("ref_req", got, 1);
        chk("ref_type", cmd_type, 2);
        tick();
        chk("ref_req_hold", {cmd_req, cmd_type}, {1'b1, 2'd2});
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("ref_req_drop", cmd_req, 0);
        for (int j = 0; j < 3; j++) begin
            ends += int'(sys_CYC_END);
            cmd_done = (j == 2);
            tick();
        end
        cmd_done = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ends += int'(sys_CYC_END);
            reqs += int'(cmd_req);
            tick();
        end
        chk("ref_no_cyc_end", ends, 0);
        chk("ref_collapsed", reqs, 0);
    endtask

    initial begin
        sys_rst_n = 1'b1; sys_A = '0; sys_ADSn = 1'b1; sys_R_Wn = 1'b1; sys_D = '0;
        sys_REF_REQ = 1'b0; init_done_i = 1'b0; cmd_ack = 1'b0; cmd_done = 1'b0;
        rd_vld_i = 1'b0; rd_data_i = '0;
        #2 sys_rst_n = 1'b0;
        tick(); tick();
        chk_zero("reset");
        sys_rst_n = 1'b1;
        tick(); tick();

        // Strobe before init: error, no command, bus still gated
        sys_ADSn = 1'b0; tick(); sys_ADSn = 1'b1;
        chk("t1_err", sys_ERR, 1);
        chk("t1_no_req", cmd_req, 0);
        chk("t1_init_low", sys_INIT_DONE, 0);
        init_done_i = 1'b1;
        chk("t1_init_same_cycle", sys_INIT_DONE, 0);
        tick();
        chk("t1_init_rise", sys_INIT_DONE, 1);

        // Fresh start with init already complete
        sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1; exp_err = 1'b0;
        tick();
        chk("reinit", {sys_INIT_DONE, sys_ERR}, 2'b10);

`ifdef SDR_REF_TIMER_EN
        begin
            int rises [$];
            bit prev = 1'b0;
            bit done_next = 1'b0;
            for (int c = 0; c < 70; c++) begin
                if (cmd_req && !prev) begin
                    rises.push_back(c);
                    chk("tmr_type", cmd_type, 2);
                end
                prev = cmd_req;
                cmd_done = done_next;
                done_next = 1'b0;
                cmd_ack = 1'b0;
                if (cmd_req) begin
                    cmd_ack = 1'b1;
                    done_next = 1'b1;
                end
                tick();
            end
            cmd_ack = 1'b0; cmd_done = 1'b0;
            chk("tmr_count", rises.size() >= 3, 1);
            if (rises.size() >= 3) begin
                chk("tmr_period0", rises[1] - rises[0], RP);
                chk("tmr_period1", rises[2] - rises[1], RP);
            end
        end
`else
        do_write(23'd512, 3, 9, 1'b1, 1'b0);
        do_read(23'd1024, 1, 0, 1'b1, 5, 1'b0, 1'b0, 1'b0);

        // Refresh request coinciding with a strobe: access first
        do_read(23'($urandom), 2, 30, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        do_refresh(3);
        // Two requests during one write collapse into a single refresh
        do_write(23'($urandom), 0, 3, 1'b0, 1'b1);
        do_refresh(3);
        sys_REF_REQ = 1'b1; tick(); sys_REF_REQ = 1'b0;
        do_refresh(3);

        for (int t = 0; t < 10; t++) begin
            bit rw = 1'($urandom_range(1));
            bit rf = ($urandom_range(3) == 0);
            logic [23:1] a = 23'($urandom);
            int ad = $urandom_range(4);
            int dn = $urandom_range(14);
            if (rw) do_read(a, ad, 30, 1'b0, dn, rf, 1'b0, 1'b0);
            else    do_write(a, ad, dn, 1'b0, rf);
            if (rf) do_refresh(3);
            if ($urandom_range(3) == 0) begin
                sys_REF_REQ = 1'b1; tick(); sys_REF_REQ = 1'b0;
                do_refresh(3);
            end
            repeat ($urandom_range(2)) tick();
        end

        // Strobe while a command is pending: ignored, flags error
        do_read(23'h2345, 2, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of write beats
        begin
            int ends = 0;
            int reqs = 0;
            sys_A = 23'd77; sys_R_Wn = 1'b0; sys_ADSn = 1'b0; tick(); sys_ADSn = 1'b1;
            repeat (BL) begin sys_D = 16'($urandom | 1); tick(); end
            cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
            repeat (4) tick();
            chk("t6_in_wdata", wr_req, 1);
            #2 sys_rst_n = 1'b0;
            #1 chk_zero("t6_async");
            init_done_i = 1'b0; exp_err = 1'b0;
            tick();
            sys_rst_n = 1'b1;
            for (int j = 0; j < 4; j++) begin
                ends += int'(sys_CYC_END);
                reqs += int'(cmd_req) + int'(wr_req);
                tick();
            end
            chk("t6_no_cyc_end", ends, 0);
            chk("t6_quiet", reqs, 0);
            chk("t6_wait_init", sys_INIT_DONE, 0);
            init_done_i = 1'b1;
            tick();
            chk("t6_init_rise", sys_INIT_DONE, 1);
        end

        // Surplus read beat is dropped and flags error
        chk("pre_extra_err", sys_ERR, 0);
        do_read(23'h1abc, 0, 0, 1'b0, 12, 1'b0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

endmodule
